fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fq_storage.sv | 71 +++++++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU-wide types and constants.
// Provides the datapath width, instruction width, sequential fetch increment
// and the fetch-entry record {pc, instr} used by the fetch queue.
package cpu_pkg;

    localparam int unsigned XLEN = 32'd32;
    localparam int unsigned ILEN = 32'd32;

    localparam logic [XLEN-1:0] FETCH_INC     = 32'h0000_0004;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force a redirect target onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

    // Sequential successor; the 32-bit add wraps 0xFFFF_FFFC to 0x0.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + FETCH_INC;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// fq_storage -- circular entry buffer for the fetch queue.
// Holds DEPTH fetch entries, the read/write pointers and the occupancy count.
// Pointers wrap naturally because DEPTH is a power of two. The caller is
// responsible for never writing when full without a simultaneous read and
// never reading when empty. Reset is synchronous, active-low.
module fq_storage
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  fetch_entry_t             wr_entry,
    input  logic                     rd_en,
    output fetch_entry_t             rd_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    fetch_entry_t     mem_r [DEPTH];

    // Pointer and occupancy bookkeeping; reset and clear both empty the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en, rd_en})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry array write; contents are never cleared, only pointers are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end
    end

    // Head entry and occupancy presented to the controller.
    always_comb begin
        rd_entry = mem_r[rd_ptr_r];
        count    = count_r;
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch front end with a small decoupling queue.
// Owns the fetch PC, issues combinational reads to instruction memory and
// pushes {pc, instr} into fq_storage; the head is offered to IF/ID.
// A flush (taken branch/jump) empties the queue and redirects fetch; it has
// priority over enqueue and dequeue. start_i is a synchronous active-low reset.
// Optional build macro: FETCH_QUEUE_BYPASS_EN -- when the queue is empty and
// the consumer is ready, the instruction being fetched is handed straight to
// the output in the same cycle without being stored.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   start_i,
    output logic [XLEN-1:0]        imem_addr_o,
    input  logic [ILEN-1:0]        imem_instr_i,
    input  logic                   flush_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    input  logic                   deq_ready_i,
    output logic                   deq_valid_o,
    output logic [XLEN-1:0]        deq_pc_o,
    output logic [ILEN-1:0]        deq_instr_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_r;
    logic [CNT_W-1:0] count_s;
    fetch_entry_t     head_s;
    fetch_entry_t     wr_entry_s;
    logic             empty_s;
    logic             full_s;
    logic             stored_valid_s;
    logic             bypass_s;
    logic             deq_s;
    logic             enq_s;
    logic             advance_s;

    // Enqueue/dequeue/bypass decisions for this cycle.
    always_comb begin
        empty_s        = (count_s == {CNT_W{1'b0}});
        full_s         = (count_s == CNT_W'(DEPTH));
        stored_valid_s = !empty_s && !flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s       = start_i && empty_s && !flush_i && deq_ready_i;
`else
        bypass_s       = 1'b0;
`endif
        deq_s          = stored_valid_s && deq_ready_i;
        // Full-and-draining still accepts a new entry: the slot frees this edge.
        enq_s          = start_i && !flush_i && !bypass_s && (!full_s || deq_s);
        advance_s      = enq_s || bypass_s;
        wr_entry_s     = '{pc: fetch_pc_r, instr: imem_instr_i};
    end

    // Fetch PC: reset, redirect on flush, otherwise step only when the fetch is consumed.
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            fetch_pc_r <= RESET_PC;
        end else if (flush_i) begin
            fetch_pc_r <= align_pc(redirect_pc_i);
        end else if (advance_s) begin
            fetch_pc_r <= next_pc(fetch_pc_r);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk_i),
        .rst_n    (start_i),
        .clear    (flush_i),
        .wr_en    (enq_s),
        .wr_entry (wr_entry_s),
        .rd_en    (deq_s),
        .rd_entry (head_s),
        .count    (count_s)
    );

    // Consumer-facing outputs: queue head, or the live fetch when bypassing.
    always_comb begin
        imem_addr_o = fetch_pc_r;
        count_o     = count_s;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass_s) begin
            deq_valid_o = 1'b1;
            deq_pc_o    = fetch_pc_r;
            deq_instr_o = imem_instr_i;
        end else begin
            deq_valid_o = stored_valid_s;
            deq_pc_o    = head_s.pc;
            deq_instr_o = head_s.instr;
        end
`else
        deq_valid_o = stored_valid_s;
        deq_pc_o    = head_s.pc;
        deq_instr_o = head_s.instr;
`endif
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed self-checking bench for fetch_queue (default build).
// Instruction memory is modelled as a fixed function of the address.
module tb_fetch_queue;

    logic        clk;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] imem_model(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = imem_model(imem_addr);

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .start_i       (start),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .flush_i       (flush),
        .redirect_pc_i (redirect_pc),
        .deq_ready_i   (deq_ready),
        .deq_valid_o   (deq_valid),
        .deq_pc_o      (deq_pc),
        .deq_instr_o   (deq_instr),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'd0, deq_valid}, 32'd1);
        check_eq({tag, "_pc"}, deq_pc, pc);
        check_eq({tag, "_instr"}, deq_instr, imem_model(pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        start       = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'h0000_0000;
        deq_ready   = 1'b1;

        // Reset
        step();
        step();
        check_eq("rst_count", {29'd0, count}, 32'd0);
        check_eq("rst_valid", {31'd0, deq_valid}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0000_0000);
        start = 1'b1;
        #1;
        check_eq("first_addr", imem_addr, 32'h0000_0000);

        // Streaming with consumer always ready: 0x0, 0x4, 0x8
        step();
        check_head("stream0", 32'h0000_0000);
        check_eq("stream0_count", {29'd0, count}, 32'd1);
        check_eq("stream0_addr", imem_addr, 32'h0000_0004);
        step();
        check_head("stream1", 32'h0000_0004);
        check_eq("stream1_count", {29'd0, count}, 32'd1);
        step();
        check_head("stream2", 32'h0000_0008);
        check_eq("stream2_addr", imem_addr, 32'h0000_000C);

        // Reset again, then stall the consumer until the queue saturates
        start     = 1'b0;
        deq_ready = 1'b0;
        step();
        check_eq("rst2_count", {29'd0, count}, 32'd0);
        check_eq("rst2_addr", imem_addr, 32'h0000_0000);
        start = 1'b1;
        step();
        step();
        check_eq("fill2_count", {29'd0, count}, 32'd2);
        for (int i = 0; i < 4; i++) step();
        check_eq("full_count", {29'd0, count}, 32'd4);
        check_eq("full_addr", imem_addr, 32'h0000_0010);
        check_head("full_head", 32'h0000_0000);

        // Full with one dequeue: swap in place, pointers wrap
        deq_ready = 1'b1;
        step();
        check_eq("swap_count", {29'd0, count}, 32'd4);
        check_head("swap_head", 32'h0000_0004);
        check_eq("swap_addr", imem_addr, 32'h0000_0014);
        step();
        check_head("wrap_head0", 32'h0000_0008);
        step();
        check_head("wrap_head1", 32'h0000_000C);
        check_eq("wrap_count", {29'd0, count}, 32'd4);
        check_eq("wrap_addr", imem_addr, 32'h0000_001C);
        deq_ready = 1'b0;

        // Flush masks valid immediately and empties the queue
        flush       = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check_eq("flush_valid_mask", {31'd0, deq_valid}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check_eq("flush1_count", {29'd0, count}, 32'd0);
        check_eq("flush1_valid", {31'd0, deq_valid}, 32'd0);
        check_eq("flush1_addr", imem_addr, 32'h0000_0100);
        step();
        step();
        step();
        check_eq("three_count", {29'd0, count}, 32'd3);
        check_eq("three_addr", imem_addr, 32'h0000_010C);
        check_head("three_head", 32'h0000_0100);

        // Flush with 3 queued to an unaligned target
        flush       = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        flush = 1'b0;
        #1;
        check_eq("flush2_count", {29'd0, count}, 32'd0);
        check_eq("flush2_valid", {31'd0, deq_valid}, 32'd0);
        check_eq("flush2_addr", imem_addr, 32'h0000_0200);
        deq_ready = 1'b1;
        step();
        check_head("flush2_head", 32'h0000_0200);
        check_eq("flush2_next_addr", imem_addr, 32'h0000_0204);

        // Fetch PC wraps past the top of the address space
        deq_ready   = 1'b0;
        flush       = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        #1;
        check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check_eq("pcwrap_addr", imem_addr, 32'h0000_0000);
        check_head("pcwrap_head", 32'hFFFF_FFFC);
        step();
        check_eq("stall_count", {29'd0, count}, 32'd2);
        check_head("stall_head", 32'hFFFF_FFFC);
        check_eq("stall_addr", imem_addr, 32'h0000_0004);

        // Reset mid-stream with 2 queued
        start = 1'b0;
        step();
        check_eq("rst3_valid", {31'd0, deq_valid}, 32'd0);
        check_eq("rst3_count", {29'd0, count}, 32'd0);
        check_eq("rst3_addr", imem_addr, 32'h0000_0000);
        start = 1'b1;
        step();
        check_head("rst3_head", 32'h0000_0000);
        check_eq("rst3_after_count", {29'd0, count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
